// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter that shares one 4:1 single-bit mux among four requesters.
// A hold limit makes each owner release the mux after at most MAX_HOLD cycles.
module rr_mux4_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Req,
  input  logic [3:0] MuxIn,
  output logic [3:0] Gnt,
  output logic [1:0] Sel,
  output logic       Busy,
  output logic       MuxOut,
  output logic       OutValid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic       busy_q, busy_d;
  logic       mux_out_q, mux_out_d;
  logic       out_valid_q, out_valid_d;

  logic [1:0] base;
  logic [1:0] win;
  logic       found;
  logic       keep;

  // Rotated scan: the owner itself is checked last, so it only wins when alone.
  always_comb begin
    base  = (state_q == GRANT) ? sel_q : last_q;
    win   = base;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!found && Req[base + 2'(i)]) begin
        win   = base + 2'(i);
        found = 1'b1;
      end
    end
  end

  assign keep = (state_q == GRANT) && Req[sel_q] && (hold_q < HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    last_d      = last_q;
    hold_d      = hold_q;
    busy_d      = busy_q;
    mux_out_d   = busy_q & MuxIn[sel_q];
    out_valid_d = busy_q;
    if (keep) begin
      hold_d = hold_q + 8'd1;
    end else if (found) begin
      state_d = GRANT;
      gnt_d   = 4'b0001 << win;
      sel_d   = win;
      last_d  = win;
      busy_d  = 1'b1;
      hold_d  = '0;
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
      busy_d  = 1'b0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      last_q      <= 2'd3;
      hold_q      <= '0;
      busy_q      <= 1'b0;
      mux_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      mux_out_q   <= mux_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Gnt      = gnt_q;
  assign Sel      = sel_q;
  assign Busy     = busy_q;
  assign MuxOut   = mux_out_q;
  assign OutValid = out_valid_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: two instances (MAX_HOLD 8 and 4) against a
// behavioural round-robin model, with directed scenarios and random traffic.
module tb_rr_mux4_arbiter;

  logic       Clk;
  logic       Rst;
  logic [3:0] Req;
  logic [3:0] MuxIn;

  logic [3:0] gnt8, gnt4;
  logic [1:0] sel8, sel4;
  logic       busy8, busy4;
  logic       out8, out4;
  logic       vld8, vld4;

  int errors;
  int checks;

  int   m_own[2];
  int   m_last[2];
  int   m_hold[2];
  bit   m_busy[2];
  bit   m_out[2];
  bit   m_vld[2];
  int   m_sel[2];

  rr_mux4_arbiter #(.MAX_HOLD(8)) dut8 (
    .Clk(Clk), .Rst(Rst), .Req(Req), .MuxIn(MuxIn),
    .Gnt(gnt8), .Sel(sel8), .Busy(busy8),
    .MuxOut(out8), .OutValid(vld8)
  );

  rr_mux4_arbiter #(.MAX_HOLD(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .Req(Req), .MuxIn(MuxIn),
    .Gnt(gnt4), .Sel(sel4), .Busy(busy4),
    .MuxOut(out4), .OutValid(vld4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k]  = 0;
      m_last[k] = 3;
      m_hold[k] = 0;
      m_busy[k] = 0;
      m_out[k]  = 0;
      m_vld[k]  = 0;
      m_sel[k]  = 0;
    end
  endtask

  // One clock edge of the arbiter's rules, in plain integer terms.
  task automatic model_step(input logic [3:0] req, input logic [3:0] din);
    int mx, base, c;
    bit got;
    for (int k = 0; k < 2; k++) begin
      mx = (k == 0) ? 8 : 4;
      m_out[k] = m_busy[k] ? din[m_sel[k]] : 1'b0;
      m_vld[k] = m_busy[k];
      if (m_busy[k] && req[m_own[k]] && m_hold[k] < mx - 1) begin
        m_hold[k]++;
      end else begin
        base = m_busy[k] ? m_own[k] : m_last[k];
        got  = 0;
        for (int i = 1; i <= 4; i++) begin
          c = (base + i) % 4;
          if (!got && req[c]) begin
            got      = 1;
            m_own[k] = c;
          end
        end
        m_hold[k] = 0;
        if (got) begin
          m_busy[k] = 1;
          m_last[k] = m_own[k];
          m_sel[k]  = m_own[k];
        end else begin
          m_busy[k] = 0;
        end
      end
    end
  endtask

  function automatic logic [8:0] model_vec(input int k);
    logic [3:0] g;
    logic [1:0] s;
    g = m_busy[k] ? 4'(1 << m_sel[k]) : 4'b0000;
    s = 2'(m_sel[k]);
    return {g, s, m_busy[k], m_out[k], m_vld[k]};
  endfunction

  task automatic tick();
    @(posedge Clk);
    model_step(Req, MuxIn);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    model_reset();
    #1;
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] o8, o4;
    Req   = 4'b0010;
    MuxIn = 4'b1111;
    tick();
    tick();
    tick();
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_busy got=%b want=1", busy8);
    end
    checks++;
    Rst = 1'b1;
    model_reset();
    #1;
    o8 = {gnt8, sel8, busy8, out8, vld8};
    o4 = {gnt4, sel4, busy4, out4, vld4};
    if (o8 !== 9'b0) begin
      errors++;
      $display("FAIL reset_async8 got=%b want=%b", o8, 9'b0);
    end
    checks++;
    if (o4 !== 9'b0) begin
      errors++;
      $display("FAIL reset_async4 got=%b want=%b", o4, 9'b0);
    end
    checks++;
    Req = 4'b0000;
    Rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    Req   = 4'b0100;
    MuxIn = 4'b0100;
    tick();
    if (gnt8 !== 4'b0100 || sel8 !== 2'd2) begin
      errors++;
      $display("FAIL single_gnt got=%b/%0d want=0100/2", gnt8, sel8);
    end
    checks++;
    tick();
    if (out8 !== 1'b1 || vld8 !== 1'b1) begin
      errors++;
      $display("FAIL single_data got=%b%b want=11", out8, vld8);
    end
    checks++;
  endtask

  task automatic test_rotation();
    logic [3:0] want;
    do_reset();
    Req   = 4'b1111;
    MuxIn = 4'b1010;
    for (int t = 1; t <= 40; t++) begin
      tick();
      want = 4'(1 << (((t - 1) / 8) % 4));
      if (gnt8 !== want || busy8 !== 1'b1) begin
        errors++;
        $display("FAIL rotation t=%0d got=%b want=%b", t, gnt8, want);
      end
      checks++;
    end
  endtask

  task automatic test_handover();
    do_reset();
    Req = 4'b0010;
    tick();
    Req = 4'b1010;
    tick();
    if (gnt8 !== 4'b0010) begin
      errors++;
      $display("FAIL handover_hold got=%b want=0010", gnt8);
    end
    checks++;
    Req = 4'b1000;
    tick();
    if (gnt8 !== 4'b1000 || busy8 !== 1'b1 || sel8 !== 2'd3) begin
      errors++;
      $display("FAIL handover_next got=%b/%b want=1000/1", gnt8, busy8);
    end
    checks++;
  endtask

  task automatic test_expiry();
    do_reset();
    Req = 4'b0001;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (gnt4 !== 4'b0001 || {gnt4, sel4, busy4, out4, vld4} !== model_vec(1)) begin
        errors++;
        $display("FAIL expiry t=%0d got=%b want=0001", t, gnt4);
      end
      checks++;
    end
  endtask

  task automatic test_idle();
    do_reset();
    Req   = 4'b0100;
    MuxIn = 4'b0100;
    tick();
    tick();
    Req = 4'b0000;
    tick();
    if (gnt8 !== 4'b0000 || busy8 !== 1'b0 || sel8 !== 2'd2 || vld8 !== 1'b1) begin
      errors++;
      $display("FAIL idle_drop got=%b/%b/%0d/%b want=0000/0/2/1",
               gnt8, busy8, sel8, vld8);
    end
    checks++;
    tick();
    if (vld8 !== 1'b0 || out8 !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid got=%b%b want=00", vld8, out8);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [8:0] o8, o4;
    do_reset();
    for (int t = 0; t < 600; t++) begin
      Req   = 4'($urandom);
      MuxIn = 4'($urandom);
      if ($urandom_range(0, 3) == 0) Req = 4'b0000;
      if ($urandom_range(0, 99) == 0) do_reset();
      tick();
      o8 = {gnt8, sel8, busy8, out8, vld8};
      o4 = {gnt4, sel4, busy4, out4, vld4};
      if (o8 !== model_vec(0)) begin
        errors++;
        $display("FAIL random8 t=%0d got=%b want=%b", t, o8, model_vec(0));
      end
      checks++;
      if (o4 !== model_vec(1)) begin
        errors++;
        $display("FAIL random4 t=%0d got=%b want=%b", t, o4, model_vec(1));
      end
      checks++;
      if (busy8 && Req !== 4'b0 && gnt8[sel8] !== 1'b1) begin
        errors++;
        $display("FAIL gnt_sel t=%0d got=%b sel=%0d", t, gnt8, sel8);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Req    = 4'b0000;
    MuxIn  = 4'b0000;
    Rst    = 1'b1;
    model_reset();
    #12;
    Rst = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_handover();
    test_expiry();
    test_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
